// File: rtl/date_down.sv
// BCD month/day calendar down-counter with validated synchronous load.
// Wraps 01/01 -> 12/31 and flags the wrap on bout.
module date_down #(
  parameter int unsigned FEB_DAYS = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] set_month1,
  input  logic [3:0] set_month0,
  input  logic [3:0] set_day1,
  input  logic [3:0] set_day0,
  output logic [3:0] month1,
  output logic [3:0] month0,
  output logic [3:0] day1,
  output logic [3:0] day0,
  output logic       bout,
  output logic       load_err
);

  localparam logic [3:0] FEB_ONES = 4'(FEB_DAYS - 20);

  logic [3:0] m1_q, m0_q, d1_q, d0_q;
  logic [3:0] m1_n, m0_n, d1_n, d0_n;
  logic       bout_q, bout_n;
  logic       err_q, err_n;

  // Last day of a month, already in BCD {tens, ones}.
  function automatic logic [7:0] last_day(
    input logic [3:0] t,
    input logic [3:0] o
  );
    unique case ({t, o})
      8'h01, 8'h03, 8'h05, 8'h07,
      8'h08, 8'h10, 8'h12: last_day = 8'h31;
      8'h02:               last_day = {4'd2, FEB_ONES};
      default:             last_day = 8'h30;
    endcase
  endfunction

  logic       dig_ok;
  logic       mon_ok;
  logic       day_ok;
  logic       set_ok;
  logic [7:0] set_last;
  logic [7:0] set_day;

  assign dig_ok = (set_month1 <= 4'd9)
               && (set_month0 <= 4'd9)
               && (set_day1 <= 4'd9)
               && (set_day0 <= 4'd9);

  assign mon_ok = ((set_month1 == 4'd0)
                   && (set_month0 != 4'd0))
               || ((set_month1 == 4'd1)
                   && (set_month0 <= 4'd2));

  assign set_last = last_day(set_month1, set_month0);
  assign set_day  = {set_day1, set_day0};

  // With legal digits, BCD order equals numeric order.
  assign day_ok = (set_day != 8'h00)
               && (set_day <= set_last);

  assign set_ok = dig_ok && mon_ok && day_ok;

  logic       day_is_01;
  logic       mon_is_01;
  logic [3:0] pm1, pm0;
  logic [7:0] prev_last;

  assign day_is_01 = (d1_q == 4'd0) && (d0_q == 4'd1);
  assign mon_is_01 = (m1_q == 4'd0) && (m0_q == 4'd1);

  // Month borrow: 10 -> 09, otherwise ones digit drops.
  assign pm1 = (m0_q == 4'd0) ? 4'd0 : m1_q;
  assign pm0 = (m0_q == 4'd0) ? 4'd9 : m0_q - 4'd1;

  assign prev_last = last_day(pm1, pm0);

  always_comb begin
    m1_n   = m1_q;
    m0_n   = m0_q;
    d1_n   = d1_q;
    d0_n   = d0_q;
    bout_n = 1'b0;
    err_n  = 1'b0;
    if (load) begin
      if (set_ok) begin
        m1_n = set_month1;
        m0_n = set_month0;
        d1_n = set_day1;
        d0_n = set_day0;
      end else begin
        err_n = 1'b1;
      end
    end else if (en) begin
      unique case (1'b1)
        day_is_01 && mon_is_01: begin
          m1_n   = 4'd1;
          m0_n   = 4'd2;
          d1_n   = 4'd3;
          d0_n   = 4'd1;
          bout_n = 1'b1;
        end
        day_is_01 && !mon_is_01: begin
          m1_n = pm1;
          m0_n = pm0;
          d1_n = prev_last[7:4];
          d0_n = prev_last[3:0];
        end
        !day_is_01 && (d0_q != 4'd0): begin
          d0_n = d0_q - 4'd1;
        end
        d0_q == 4'd0: begin
          d1_n = d1_q - 4'd1;
          d0_n = 4'd9;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_q   <= 4'd0;
      m0_q   <= 4'd1;
      d1_q   <= 4'd0;
      d0_q   <= 4'd1;
      bout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      m1_q   <= m1_n;
      m0_q   <= m0_n;
      d1_q   <= d1_n;
      d0_q   <= d0_n;
      bout_q <= bout_n;
      err_q  <= err_n;
    end
  end

  assign month1   = m1_q;
  assign month0   = m0_q;
  assign day1     = d1_q;
  assign day0     = d0_q;
  assign bout     = bout_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_date_down.sv
// Bench for date_down: directed vector table, corner sequences,
// and a random run against a calendar model (Feb 28 and Feb 29).
module tb_date_down;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [3:0] sm1, sm0, sd1, sd0;

  logic [3:0] a_m1, a_m0, a_d1, a_d0;
  logic       a_bout, a_err;
  logic [3:0] b_m1, b_m0, b_d1, b_d0;
  logic       b_bout, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  date_down #(.FEB_DAYS(28)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .set_month1(sm1), .set_month0(sm0),
    .set_day1(sd1), .set_day0(sd0),
    .month1(a_m1), .month0(a_m0),
    .day1(a_d1), .day0(a_d0),
    .bout(a_bout), .load_err(a_err)
  );

  date_down #(.FEB_DAYS(29)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .set_month1(sm1), .set_month0(sm0),
    .set_day1(sd1), .set_day0(sd0),
    .month1(b_m1), .month0(b_m0),
    .day1(b_d1), .day0(b_d0),
    .bout(b_bout), .load_err(b_err)
  );

  typedef struct {
    logic [15:0] start;
    logic        ld;
    logic        e;
    logic [15:0] set;
    logic [15:0] exp;
    logic        ebo;
    logic        eer;
  } vec_t;

  vec_t tv[$];

  function automatic logic [17:0] a_out();
    return {a_m1, a_m0, a_d1, a_d0, a_bout, a_err};
  endfunction

  function automatic logic [17:0] b_out();
    return {b_m1, b_m0, b_d1, b_d0, b_bout, b_err};
  endfunction

  function automatic logic [15:0] bcd(input int m, input int d);
    return {4'(m / 10), 4'(m % 10), 4'(d / 10), 4'(d % 10)};
  endfunction

  function automatic int mlen(input int m, input int feb);
    case (m)
      2:           return feb;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [17:0] act,
                     input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got date=%h bout/err=%b want date=%h bout/err=%b",
               nm, act[17:2], act[1:0], exp[17:2], exp[1:0]);
    end
  endtask

  // Calendar model: plain month/day integers.
  task automatic mstep(input int feb,
                       inout int m, inout int d,
                       input bit ld, input bit e,
                       input logic [15:0] s,
                       output bit bo, output bit er);
    int  tm, td;
    bit  ok;
    bo = 1'b0;
    er = 1'b0;
    if (ld) begin
      ok = (s[15:12] <= 9) && (s[11:8] <= 9)
        && (s[7:4] <= 9) && (s[3:0] <= 9);
      tm = int'(s[15:12]) * 10 + int'(s[11:8]);
      td = int'(s[7:4]) * 10 + int'(s[3:0]);
      ok = ok && tm >= 1 && tm <= 12;
      ok = ok && td >= 1 && td <= mlen(tm, feb);
      if (ok) begin
        m = tm;
        d = td;
      end else begin
        er = 1'b1;
      end
    end else if (e) begin
      if (d > 1) begin
        d = d - 1;
      end else if (m > 1) begin
        m = m - 1;
        d = mlen(m, feb);
      end else begin
        m  = 12;
        d  = 31;
        bo = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit ld, input bit e,
                       input logic [15:0] s);
    @(negedge clk);
    load = ld;
    en   = e;
    {sm1, sm0, sd1, sd0} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    en    = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ma, da, mb, db;
    bit  boa, era, bob, erb;
    int  nbout, first_bout;
    bit  ld, e;
    logic [15:0] s;

    rst_n = 1'b0;
    load  = 1'b0;
    en    = 1'b0;
    {sm1, sm0, sd1, sd0} = 16'h0;
    #12;
    chk("reset_a", a_out(), {16'h0101, 2'b00});
    chk("reset_b", b_out(), {16'h0101, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;

    tv.push_back('{16'h0101, 0, 1, 16'h0000, 16'h1231, 1, 0});
    tv.push_back('{16'h1231, 0, 1, 16'h0000, 16'h1230, 0, 0});
    tv.push_back('{16'h0301, 0, 1, 16'h0000, 16'h0228, 0, 0});
    tv.push_back('{16'h1001, 0, 1, 16'h0000, 16'h0930, 0, 0});
    tv.push_back('{16'h0930, 0, 1, 16'h0000, 16'h0929, 0, 0});
    tv.push_back('{16'h0510, 0, 1, 16'h0000, 16'h0509, 0, 0});
    tv.push_back('{16'h1220, 0, 1, 16'h0000, 16'h1219, 0, 0});
    tv.push_back('{16'h1225, 0, 1, 16'h0000, 16'h1224, 0, 0});
    tv.push_back('{16'h0801, 0, 1, 16'h0000, 16'h0731, 0, 0});
    tv.push_back('{16'h0201, 0, 1, 16'h0000, 16'h0131, 0, 0});
    tv.push_back('{16'h1201, 0, 1, 16'h0000, 16'h1130, 0, 0});
    tv.push_back('{16'h1101, 0, 1, 16'h0000, 16'h1031, 0, 0});
    tv.push_back('{16'h0115, 1, 0, 16'h0230, 16'h0115, 0, 1});
    tv.push_back('{16'h0115, 1, 0, 16'h1301, 16'h0115, 0, 1});
    tv.push_back('{16'h0115, 1, 0, 16'h0431, 16'h0115, 0, 1});
    tv.push_back('{16'h0115, 1, 0, 16'h0005, 16'h0115, 0, 1});
    tv.push_back('{16'h0115, 1, 0, 16'h070A, 16'h0115, 0, 1});
    tv.push_back('{16'h0115, 1, 0, 16'h0100, 16'h0115, 0, 1});
    tv.push_back('{16'h0115, 1, 0, 16'h0229, 16'h0115, 0, 1});
    tv.push_back('{16'h0115, 1, 0, 16'h1A01, 16'h0115, 0, 1});
    tv.push_back('{16'h0115, 1, 0, 16'h0932, 16'h0115, 0, 1});
    tv.push_back('{16'h0101, 1, 1, 16'h0615, 16'h0615, 0, 0});
    tv.push_back('{16'h0101, 1, 0, 16'h1231, 16'h1231, 0, 0});
    tv.push_back('{16'h0101, 1, 0, 16'h0228, 16'h0228, 0, 0});
    tv.push_back('{16'h0817, 0, 0, 16'h0101, 16'h0817, 0, 0});

    foreach (tv[i]) begin
      drive(1'b1, 1'b0, tv[i].start);
      drive(tv[i].ld, tv[i].e, tv[i].set);
      chk($sformatf("vec%0d", i), a_out(),
          {tv[i].exp, tv[i].ebo, tv[i].eer});
    end

    // Pulses last one cycle; state holds with en low.
    drive(1'b1, 1'b0, 16'h0101);
    drive(1'b0, 1'b1, 16'h0000);
    chk("wrap", a_out(), {16'h1231, 2'b10});
    drive(1'b0, 1'b0, 16'h0000);
    chk("wrap_hold", a_out(), {16'h1231, 2'b00});
    drive(1'b1, 1'b0, 16'h0230);
    chk("err_pulse", a_out(), {16'h1231, 2'b01});
    drive(1'b0, 1'b0, 16'h0000);
    chk("err_clear", a_out(), {16'h1231, 2'b00});

    // Leap-February instance.
    drive(1'b1, 1'b0, 16'h0301);
    drive(1'b0, 1'b1, 16'h0000);
    chk("feb29_dec", b_out(), {16'h0229, 2'b00});
    chk("feb28_dec", a_out(), {16'h0228, 2'b00});
    drive(1'b1, 1'b0, 16'h0229);
    chk("feb29_load", b_out(), {16'h0229, 2'b00});
    chk("feb28_rej", a_out(), {16'h0228, 2'b01});

    // Asynchronous reset at 08/17 with load_err high.
    drive(1'b1, 1'b0, 16'h0817);
    drive(1'b1, 1'b0, 16'h0230);
    chk("pre_rst", a_out(), {16'h0817, 2'b01});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", a_out(), {16'h0101, 2'b00});
    chk("async_rst_b", b_out(), {16'h0101, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b0;
    en    = 1'b0;

    // Full year from 01/01.
    do_reset();
    ma = 1; da = 1; mb = 1; db = 1;
    nbout = 0;
    first_bout = -1;
    for (int c = 1; c <= 365; c++) begin
      drive(1'b0, 1'b1, 16'h0000);
      mstep(28, ma, da, 1'b0, 1'b1, 16'h0, boa, era);
      mstep(29, mb, db, 1'b0, 1'b1, 16'h0, bob, erb);
      chk($sformatf("year_a%0d", c), a_out(),
          {bcd(ma, da), boa, era});
      chk($sformatf("year_b%0d", c), b_out(),
          {bcd(mb, db), bob, erb});
      if (a_bout) begin
        nbout++;
        if (first_bout < 0) first_bout = c;
      end
    end
    chk("year_end", a_out(), {16'h0101, 2'b00});
    chk("year_bouts", 18'(nbout), 18'd1);
    chk("year_first", 18'(first_bout), 18'd1);

    // Random run against the model.
    for (int c = 0; c < 600; c++) begin
      ld = ($urandom_range(0, 4) == 0);
      e  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        s = bcd($urandom_range(1, 12), $urandom_range(1, 31));
      else
        s = 16'($urandom);
      drive(ld, e, s);
      mstep(28, ma, da, ld, e, s, boa, era);
      mstep(29, mb, db, ld, e, s, bob, erb);
      chk($sformatf("rnd_a%0d", c), a_out(),
          {bcd(ma, da), boa, era});
      chk($sformatf("rnd_b%0d", c), b_out(),
          {bcd(mb, db), bob, erb});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
